// File: rtl/fp_wire_pkg.sv
// Shared floating-point verification types: scoreboard entry layout and canonical NaN.
package fp_wire;

    localparam int unsigned FP_XLEN    = 32;
    localparam int unsigned FP_FLAGS_W = 5;
    localparam int unsigned FP_TAG_W   = 16;

    localparam logic [FP_XLEN-1:0] FP_CANON_NAN = 32'h7FC0_0000;

    typedef struct packed {
        logic [FP_XLEN-1:0]    result;
        logic [FP_FLAGS_W-1:0] flags;
        logic                  nanchk;
        logic [FP_TAG_W-1:0]   tag;
    } fp_sb_entry_type;

    typedef enum logic {
        SB_RUN  = 1'b0,
        SB_HALT = 1'b1
    } fp_sb_state_e;

endpackage

// File: rtl/fp_sb_fifo.sv
// In-order FIFO for scoreboard expectations; count register separates full from empty.
module fp_sb_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 wdata,
    output logic [W-1:0]                 rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == LVL_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full & ~clear;
    assign pop_ok  = pop & ~empty & ~clear;
    assign rdata   = mem[rd_ptr];

    // Storage is not reset; validity is tracked by the pointers and count.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fp_scoreboard.sv
// Expected-result scoreboard: queues expectations at issue and checks each fp_unit
// completion against the oldest one, with NaN masking, counting and first-fail capture.
module fp_scoreboard
    import fp_wire::*;
#(
    parameter int unsigned XLEN         = FP_XLEN,
    parameter int unsigned FLAGS_W      = FP_FLAGS_W,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned TAG_W        = FP_TAG_W,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned STOP_ON_FAIL = 1
) (
    input  logic                       reset,
    input  logic                       clock,
    input  logic                       clear,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [XLEN-1:0]            push_result,
    input  logic [FLAGS_W-1:0]         push_flags,
    input  logic                       push_nanchk,
    input  logic [TAG_W-1:0]           push_tag,
    input  logic                       dut_ready,
    input  logic [XLEN-1:0]            dut_result,
    input  logic [FLAGS_W-1:0]         dut_flags,
    output logic                       fail,
    output logic [TAG_W-1:0]           fail_tag,
    output logic [XLEN-1:0]            fail_result_diff,
    output logic [FLAGS_W-1:0]         fail_flags_diff,
    output logic [CNT_W-1:0]           pass_count,
    output logic [CNT_W-1:0]           fail_count,
    output logic                       overflow,
    output logic                       underflow,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       halted
);

    localparam int unsigned ENTRY_W = $bits(fp_sb_entry_type);

    fp_sb_state_e          state_q;
    fp_sb_state_e          state_d;
    fp_sb_entry_type       push_entry;
    fp_sb_entry_type       head;
    logic [ENTRY_W-1:0]    head_raw;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  running;
    logic                  push_en;
    logic                  pop_en;
    logic                  ovf_hit;
    logic                  udf_hit;
    logic                  nan_hit;
    logic                  mismatch;
    logic [FP_XLEN-1:0]    dut_r;
    logic [FP_XLEN-1:0]    rdiff;
    logic [FP_FLAGS_W-1:0] fdiff;

    assign running    = (state_q == SB_RUN);
    assign push_ready = ~fifo_full & running;
    assign halted     = (state_q == SB_HALT);

    assign push_entry.result = FP_XLEN'(push_result);
    assign push_entry.flags  = FP_FLAGS_W'(push_flags);
    assign push_entry.nanchk = push_nanchk;
    assign push_entry.tag    = FP_TAG_W'(push_tag);
    assign head              = head_raw;

    assign push_en = push_valid & push_ready & ~clear;
    assign ovf_hit = push_valid & fifo_full & running & ~clear;
    assign pop_en  = dut_ready & running & ~fifo_empty & ~clear;
    assign udf_hit = dut_ready & running & fifo_empty & ~clear;

    fp_sb_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .push  (push_en),
        .pop   (pop_en),
        .wdata (push_entry),
        .rdata (head_raw),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (level)
    );

    // Canonical-NaN result only has to agree on exponent and quiet bit.
    always_comb begin
        dut_r   = FP_XLEN'(dut_result);
        rdiff   = head.result ^ dut_r;
        fdiff   = head.flags ^ FP_FLAGS_W'(dut_flags);
        nan_hit = head.nanchk && (dut_r == FP_CANON_NAN);
        if (nan_hit) begin
            rdiff[31]   = 1'b0;
            rdiff[21:0] = '0;
        end
        mismatch = pop_en && ((rdiff != '0) || (fdiff != '0));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= SB_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = SB_RUN;
        end else if (running && mismatch && (STOP_ON_FAIL != 0)) begin
            state_d = SB_HALT;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fail             <= 1'b0;
            fail_tag         <= '0;
            fail_result_diff <= '0;
            fail_flags_diff  <= '0;
            pass_count       <= '0;
            fail_count       <= '0;
            overflow         <= 1'b0;
            underflow        <= 1'b0;
        end else if (clear) begin
            fail             <= 1'b0;
            fail_tag         <= '0;
            fail_result_diff <= '0;
            fail_flags_diff  <= '0;
            pass_count       <= '0;
            fail_count       <= '0;
            overflow         <= 1'b0;
            underflow        <= 1'b0;
        end else begin
            if (ovf_hit) overflow  <= 1'b1;
            if (udf_hit) underflow <= 1'b1;
            if (pop_en && !mismatch && (pass_count != '1)) begin
                pass_count <= pass_count + CNT_W'(1);
            end
            if (mismatch && (fail_count != '1)) begin
                fail_count <= fail_count + CNT_W'(1);
            end
            // Only the first mismatch since reset/clear is captured.
            if (mismatch && !fail) begin
                fail             <= 1'b1;
                fail_tag         <= TAG_W'(head.tag);
                fail_result_diff <= XLEN'(rdiff);
                fail_flags_diff  <= FLAGS_W'(fdiff);
            end
        end
    end

endmodule

// File: tb/tb_fp_scoreboard.sv
// Randomised and directed checks of fp_scoreboard against a queue-based reference model.
module tb_fp_scoreboard;

    localparam int unsigned DEPTH = 8;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  flags;
        logic        nanchk;
        logic [15:0] tag;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic        push_valid = 1'b0;
    logic        push_ready;
    logic [31:0] push_result = '0;
    logic [4:0]  push_flags = '0;
    logic        push_nanchk = 1'b0;
    logic [15:0] push_tag = '0;
    logic        dut_ready = 1'b0;
    logic [31:0] dut_result = '0;
    logic [4:0]  dut_flags = '0;
    logic        fail;
    logic [15:0] fail_tag;
    logic [31:0] fail_result_diff;
    logic [4:0]  fail_flags_diff;
    logic [31:0] pass_count;
    logic [31:0] fail_count;
    logic        overflow;
    logic        underflow;
    logic [3:0]  level;
    logic        halted;

    fp_scoreboard #(
        .XLEN(32), .FLAGS_W(5), .DEPTH(DEPTH), .TAG_W(16), .CNT_W(32), .STOP_ON_FAIL(1)
    ) dut (
        .reset(reset), .clock(clock), .clear(clear),
        .push_valid(push_valid), .push_ready(push_ready), .push_result(push_result),
        .push_flags(push_flags), .push_nanchk(push_nanchk), .push_tag(push_tag),
        .dut_ready(dut_ready), .dut_result(dut_result), .dut_flags(dut_flags),
        .fail(fail), .fail_tag(fail_tag), .fail_result_diff(fail_result_diff),
        .fail_flags_diff(fail_flags_diff), .pass_count(pass_count), .fail_count(fail_count),
        .overflow(overflow), .underflow(underflow), .level(level), .halted(halted)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    exp_t        m_q[$];
    logic        m_halt;
    int          m_pass, m_failc;
    logic        m_fail, m_ovf, m_udf;
    logic [15:0] m_tag;
    logic [31:0] m_rd;
    logic [4:0]  m_fd;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_halt = 1'b0; m_pass = 0; m_failc = 0;
        m_fail = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        m_tag = '0; m_rd = '0; m_fd = '0;
    endtask

    task automatic model_step(input logic pv, input exp_t pe, input logic dr,
                              input logic [31:0] dres, input logic [4:0] dfl, input logic clr);
        bit          was_full;
        exp_t        e;
        logic [31:0] rd;
        logic [4:0]  fd;
        if (clr) begin
            model_reset();
            return;
        end
        if (m_halt) return;
        was_full = (m_q.size() == DEPTH);
        if (dr) begin
            if (m_q.size() == 0) begin
                m_udf = 1'b1;
            end else begin
                e  = m_q.pop_front();
                fd = e.flags ^ dfl;
                if (e.nanchk && dres == 32'h7FC0_0000) rd = (e.result ^ dres) & 32'h7FC0_0000;
                else rd = e.result ^ dres;
                if (rd == 0 && fd == 0) begin
                    m_pass++;
                end else begin
                    m_failc++;
                    if (!m_fail) begin
                        m_fail = 1'b1; m_tag = e.tag; m_rd = rd; m_fd = fd;
                    end
                    m_halt = 1'b1;
                end
            end
        end
        if (pv) begin
            if (was_full) m_ovf = 1'b1;
            else m_q.push_back(pe);
        end
    endtask

    task automatic check_all(input string ph);
        check_eq({ph, ".level"}, 64'(level), 64'(m_q.size()));
        check_eq({ph, ".push_ready"}, 64'(push_ready), 64'(!m_halt && m_q.size() < DEPTH));
        check_eq({ph, ".halted"}, 64'(halted), 64'(m_halt));
        check_eq({ph, ".pass_count"}, 64'(pass_count), 64'(m_pass));
        check_eq({ph, ".fail_count"}, 64'(fail_count), 64'(m_failc));
        check_eq({ph, ".fail"}, 64'(fail), 64'(m_fail));
        check_eq({ph, ".fail_tag"}, 64'(fail_tag), 64'(m_tag));
        check_eq({ph, ".fail_result_diff"}, 64'(fail_result_diff), 64'(m_rd));
        check_eq({ph, ".fail_flags_diff"}, 64'(fail_flags_diff), 64'(m_fd));
        check_eq({ph, ".overflow"}, 64'(overflow), 64'(m_ovf));
        check_eq({ph, ".underflow"}, 64'(underflow), 64'(m_udf));
    endtask

    // One clock cycle: drive, advance model, clock, then check just after the edge.
    task automatic cyc(input string ph, input logic pv, input logic [31:0] pr, input logic [4:0] pf,
                       input logic pn, input logic [15:0] pt, input logic dr,
                       input logic [31:0] dres, input logic [4:0] dfl, input logic clr);
        exp_t pe;
        pe.result = pr; pe.flags = pf; pe.nanchk = pn; pe.tag = pt;
        push_valid = pv; push_result = pr; push_flags = pf; push_nanchk = pn; push_tag = pt;
        dut_ready = dr; dut_result = dres; dut_flags = dfl; clear = clr;
        model_step(pv, pe, dr, dres, dfl, clr);
        @(posedge clock);
        #1;
        push_valid = 1'b0; dut_ready = 1'b0; clear = 1'b0;
        check_all(ph);
    endtask

    task automatic idle(input string ph);
        cyc(ph, 0, '0, '0, 0, '0, 0, '0, '0, 0);
    endtask

    task automatic do_clear(input string ph);
        cyc(ph, 0, '0, '0, 0, '0, 0, '0, '0, 1);
    endtask

    initial begin
        exp_t        h;
        logic        pv, dr, clr, pn;
        logic [31:0] pr, dres;
        logic [4:0]  pf, dfl;

        model_reset();
        #12 reset = 1'b1;
        #1;
        check_all("reset");

        // Three matching results returned after a gap
        cyc("t1", 1, 32'h3F80_0000, 5'h00, 1, 16'd1, 0, '0, '0, 0);
        cyc("t1", 1, 32'h4000_0000, 5'h00, 1, 16'd2, 0, '0, '0, 0);
        cyc("t1", 1, 32'h7F80_0000, 5'h05, 1, 16'd3, 0, '0, '0, 0);
        idle("t1");
        cyc("t1", 0, '0, '0, 0, '0, 1, 32'h3F80_0000, 5'h00, 0);
        cyc("t1", 0, '0, '0, 0, '0, 1, 32'h4000_0000, 5'h00, 0);
        cyc("t1", 0, '0, '0, 0, '0, 1, 32'h7F80_0000, 5'h05, 0);
        check_eq("t1.pass3", 64'(pass_count), 64'd3);
        check_eq("t1.level0", 64'(level), 64'd0);

        // NaN masking on and off
        cyc("nan", 1, 32'hFFC0_0001, 5'h00, 1, 16'd10, 0, '0, '0, 0);
        cyc("nan", 0, '0, '0, 0, '0, 1, 32'h7FC0_0000, 5'h00, 0);
        check_eq("nan.masked_pass", 64'(pass_count), 64'd4);
        cyc("nan", 1, 32'hFFC0_0001, 5'h00, 0, 16'd11, 0, '0, '0, 0);
        cyc("nan", 0, '0, '0, 0, '0, 1, 32'h7FC0_0000, 5'h00, 0);
        check_eq("nan.unmasked_diff", 64'(fail_result_diff), 64'h8000_0001);
        check_eq("nan.unmasked_fail", 64'(fail), 64'd1);
        do_clear("nan");

        // Halt on mismatch, ignore traffic while halted, clear recovers
        cyc("halt", 1, 32'h3F80_0000, 5'h00, 1, 16'd7, 0, '0, '0, 0);
        cyc("halt", 0, '0, '0, 0, '0, 1, 32'h3F80_0001, 5'h00, 0);
        check_eq("halt.tag", 64'(fail_tag), 64'd7);
        check_eq("halt.halted", 64'(halted), 64'd1);
        check_eq("halt.push_ready", 64'(push_ready), 64'd0);
        cyc("halt", 1, 32'h1234_5678, 5'h01, 0, 16'd8, 1, 32'h0000_0000, 5'h1F, 0);
        check_eq("halt.ignored_fail_count", 64'(fail_count), 64'd1);
        do_clear("halt");
        check_eq("halt.cleared_run", 64'(halted), 64'd0);

        // Full FIFO, overflow drop, simultaneous push/pop
        for (int i = 0; i < DEPTH; i++)
            cyc("full", 1, 32'(i) + 32'h100, 5'(i), 0, 16'(i), 0, '0, '0, 0);
        check_eq("full.push_ready", 64'(push_ready), 64'd0);
        cyc("full", 1, 32'hDEAD_BEEF, 5'h00, 0, 16'd99, 0, '0, '0, 0);
        check_eq("full.overflow", 64'(overflow), 64'd1);
        check_eq("full.level", 64'(level), 64'(DEPTH));
        cyc("full", 0, '0, '0, 0, '0, 1, 32'h100, 5'd0, 0);
        cyc("full", 1, 32'h0ABC_0000, 5'h02, 0, 16'd50, 1, 32'h101, 5'd1, 0);
        check_eq("full.pushpop_level", 64'(level), 64'(DEPTH - 1));
        do_clear("full");

        // Compare with empty FIFO, including same-cycle push
        cyc("udf", 1, 32'h4040_0000, 5'h00, 0, 16'd60, 1, 32'h4040_0000, 5'h00, 0);
        check_eq("udf.flag", 64'(underflow), 64'd1);
        check_eq("udf.pass", 64'(pass_count), 64'd0);
        do_clear("udf");

        // Asynchronous reset with five entries outstanding
        for (int i = 0; i < 5; i++)
            cyc("arst", 1, 32'h2000_0000 + 32'(i), 5'h00, 0, 16'(i), 0, '0, '0, 0);
        check_eq("arst.level5", 64'(level), 64'd5);
        reset = 1'b0;
        model_reset();
        #1;
        check_all("arst");
        #2 reset = 1'b1;
        @(posedge clock);
        #1;

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            pv = ($urandom_range(0, 99) < 50);
            pn = $urandom_range(0, 1);
            pf = 5'($urandom());
            if ($urandom_range(0, 99) < 20) pr = 32'h7FC0_0000 | ($urandom() & 32'h803F_FFFF);
            else pr = $urandom();
            dres = $urandom(); dfl = 5'($urandom());
            if (m_q.size() > 0) begin
                dr = ($urandom_range(0, 99) < 45);
                h  = m_q[0];
                dres = h.result; dfl = h.flags;
                if (h.result[30:22] == 9'h1FF && $urandom_range(0, 1) == 1) dres = 32'h7FC0_0000;
                if ($urandom_range(0, 99) < 4) dres = dres ^ (32'h1 << $urandom_range(0, 31));
                if ($urandom_range(0, 99) < 3) dfl = dfl ^ 5'h01;
            end else begin
                dr = ($urandom_range(0, 99) < 5);
            end
            clr = m_halt ? ($urandom_range(0, 99) < 20) : ($urandom_range(0, 999) < 5);
            cyc("rand", pv, pr, pf, pn, 16'(i), dr, dres, dfl, clr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
